// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: constants and types shared by the AES decryption datapath blocks.
//   AES_NBYTES          bytes in one 128-bit AES state
//   BYTE_W              width of a byte lane
//   INV_SBOX_RD_LATENCY default read latency of the shared inverse S-box RAM
//   reader_state_e      inverse S-box reader FSM encoding
package aes_dec_pkg;

  localparam int unsigned AES_NBYTES          = 16;
  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned INV_SBOX_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    StWaitTable = 2'd0,
    StIdle      = 2'd1,
    StRead      = 2'd2,
    StDone      = 2'd3
  } reader_state_e;

endpackage

// File: rtl/inv_sbox_reader_if.sv
// inv_sbox_reader_if: signal bundle around the inverse S-box reader.
//   ram_ready                      table fully loaded (level)
//   in_valid / in_ready / in_state input state handshake, byte 0 in the MSBs
//   rd_en / rd_addr / rd_data      synchronous read port of the inverse S-box RAM
//   out_valid / out_ready / out_state  substituted state handshake
// Modports:
//   slave  - the reader itself
//   master - its environment (round datapath, consumer, RAM read port, loader status)
interface inv_sbox_reader_if import aes_dec_pkg::*; #(
  parameter int unsigned NBYTES = AES_NBYTES
) ();

  logic                     ram_ready;
  logic                     in_valid;
  logic                     in_ready;
  logic [0:BYTE_W*NBYTES-1] in_state;
  logic                     rd_en;
  logic [0:BYTE_W-1]        rd_addr;
  logic [0:BYTE_W-1]        rd_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [0:BYTE_W*NBYTES-1] out_state;

  modport slave (
    input  ram_ready, in_valid, in_state, rd_data, out_ready,
    output in_ready, rd_en, rd_addr, out_valid, out_state
  );

  modport master (
    output ram_ready, in_valid, in_state, rd_data, out_ready,
    input  in_ready, rd_en, rd_addr, out_valid, out_state
  );

endinterface

// File: rtl/inv_sbox_ram.sv
// inv_sbox_ram: 256x8 inverse S-box table storage.
//   clk                        rising-edge clock
//   wr_en / wr_addr / wr_data  loader-side write port
//   rd_en / rd_addr            read strobe and address
//   rd_data                    read data, valid RD_LATENCY cycles after the strobe (1..2)
// The table contents are undefined until the loader has written every entry.
module inv_sbox_ram import aes_dec_pkg::*; #(
  parameter int unsigned RD_LATENCY = INV_SBOX_RD_LATENCY
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [0:BYTE_W-1] rd_addr,
  output logic [0:BYTE_W-1] rd_data
);

  logic [BYTE_W-1:0] mem_q     [2**BYTE_W];
  logic [BYTE_W-1:0] rd_pipe_q [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Stage 0 is the array read; further stages are plain output registers.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_pipe_q[0] <= mem_q[rd_addr];
    end
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign rd_data = rd_pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/inv_sbox_reader.sv
// inv_sbox_reader: InvSubBytes over a 128-bit state using the shared inverse S-box RAM.
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    inv_sbox_reader_if.slave: ram_ready, input handshake, RAM read port,
//          output handshake
// One state is accepted from IDLE, its NBYTES bytes are looked up one per cycle through
// the RAM read port, and the result is held in DONE until the consumer takes it.
// ram_ready falling while reading aborts the transaction without a result.
module inv_sbox_reader import aes_dec_pkg::*; #(
  parameter int unsigned NBYTES     = AES_NBYTES,
  parameter int unsigned RD_LATENCY = INV_SBOX_RD_LATENCY
) (
  input logic              clk,
  input logic              reset,
  inv_sbox_reader_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(NBYTES);
  localparam int unsigned     StateW  = BYTE_W * NBYTES;
  localparam logic [CntW-1:0] LastIdx = CntW'(NBYTES - 1);

  reader_state_e         state_q, state_d;
  logic [0:StateW-1]     lat_state_q, lat_state_d;
  logic [0:StateW-1]     out_state_q, out_state_d;
  logic [CntW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0]       cap_cnt_q, cap_cnt_d;
  logic                  issue_done_q, issue_done_d;
  // Delayed copy of rd_en; the top bit marks a cycle whose rd_data belongs to cap_cnt_q.
  logic [RD_LATENCY-1:0] vld_q, vld_d;

  logic rd_en;
  logic in_ready;

  assign rd_en = (state_q == StRead) && !issue_done_q;

  always_comb begin
    state_d      = state_q;
    lat_state_d  = lat_state_q;
    out_state_d  = out_state_q;
    issue_cnt_d  = issue_cnt_q;
    cap_cnt_d    = cap_cnt_q;
    issue_done_d = issue_done_q;
    vld_d[0]     = rd_en;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    in_ready     = 1'b0;

    unique case (state_q)
      StWaitTable: begin
        if (bus.ram_ready) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        in_ready = bus.ram_ready;
        if (!bus.ram_ready) begin
          state_d = StWaitTable;
        end else if (bus.in_valid) begin
          state_d      = StRead;
          lat_state_d  = bus.in_state;
          issue_cnt_d  = '0;
          cap_cnt_d    = '0;
          issue_done_d = 1'b0;
          vld_d        = '0;
        end
      end
      StRead: begin
        if (!bus.ram_ready) begin
          // Abort: strobe drops next cycle, returns still in the pipe are discarded.
          state_d = StWaitTable;
          vld_d   = '0;
        end else begin
          if (rd_en) begin
            if (issue_cnt_q == LastIdx) begin
              issue_done_d = 1'b1;
            end else begin
              issue_cnt_d = issue_cnt_q + 1'b1;
            end
          end
          if (vld_q[RD_LATENCY-1]) begin
            out_state_d[BYTE_W*cap_cnt_q +: BYTE_W] = bus.rd_data;
            if (cap_cnt_q == LastIdx) begin
              state_d = StDone;
            end else begin
              cap_cnt_d = cap_cnt_q + 1'b1;
            end
          end
        end
      end
      StDone: begin
        // A result already in DONE is still delivered if the table goes away.
        if (bus.out_ready) begin
          state_d = bus.ram_ready ? StIdle : StWaitTable;
        end
      end
      default: state_d = StWaitTable;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StWaitTable;
      lat_state_q  <= '0;
      out_state_q  <= '0;
      issue_cnt_q  <= '0;
      cap_cnt_q    <= '0;
      issue_done_q <= 1'b0;
      vld_q        <= '0;
    end else begin
      state_q      <= state_d;
      lat_state_q  <= lat_state_d;
      out_state_q  <= out_state_d;
      issue_cnt_q  <= issue_cnt_d;
      cap_cnt_q    <= cap_cnt_d;
      issue_done_q <= issue_done_d;
      vld_q        <= vld_d;
    end
  end

  // The issue counter parks on the last byte, so rd_addr holds once issue completes.
  assign bus.in_ready  = in_ready;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = lat_state_q[BYTE_W*issue_cnt_q +: BYTE_W];
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_state = out_state_q;

endmodule

// File: tb/tb_inv_sbox_reader.sv
// Directed bench for inv_sbox_reader. Two reader+RAM pairs share the stimulus:
// b1 uses RD_LATENCY=1, b2 uses RD_LATENCY=2; sel routes in_valid and the observed
// outputs to one of them. The bench plays the loader: it writes the inverse S-box
// into both RAMs, then raises ram_ready.
module tb_inv_sbox_reader;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic         ram_ready = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         sel       = 1'b0;
  logic [127:0] in_state  = '0;
  logic         wr_en     = 1'b0;
  logic [7:0]   wr_addr   = '0;
  logic [7:0]   wr_data   = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inv_sbox_reader_if #(.NBYTES(16)) b1 ();
  inv_sbox_reader_if #(.NBYTES(16)) b2 ();

  assign b1.ram_ready = ram_ready;
  assign b2.ram_ready = ram_ready;
  assign b1.in_valid  = in_valid && !sel;
  assign b2.in_valid  = in_valid && sel;
  assign b1.in_state  = in_state;
  assign b2.in_state  = in_state;
  assign b1.out_ready = out_ready;
  assign b2.out_ready = out_ready;

  inv_sbox_reader #(.NBYTES(16), .RD_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  inv_sbox_reader #(.NBYTES(16), .RD_LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  inv_sbox_ram #(.RD_LATENCY(1)) ram1 (
    .clk(clk), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(b1.rd_en), .rd_addr(b1.rd_addr), .rd_data(b1.rd_data)
  );
  inv_sbox_ram #(.RD_LATENCY(2)) ram2 (
    .clk(clk), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(b2.rd_en), .rd_addr(b2.rd_addr), .rd_data(b2.rd_data)
  );

  logic         m_in_ready, m_rd_en, m_out_valid;
  logic [7:0]   m_rd_addr;
  logic [127:0] m_out_state;
  assign m_in_ready  = sel ? b2.in_ready  : b1.in_ready;
  assign m_rd_en     = sel ? b2.rd_en     : b1.rd_en;
  assign m_rd_addr   = sel ? b2.rd_addr   : b1.rd_addr;
  assign m_out_valid = sel ? b2.out_valid : b1.out_valid;
  assign m_out_state = sel ? b2.out_state : b1.out_state;

  localparam logic [127:0] ST1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] EX1 = 128'h52096ad53036a538bf40a39e81f3d7fb;
  localparam logic [127:0] ST2 = 128'h63ff0001010101010101010101010101;
  localparam logic [127:0] EX2 = 128'h007d5209090909090909090909090909;
  localparam logic [127:0] ST3 = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] EX3 = 128'h7ce339829b2fff87348e4344c4dee9cb;
  localparam logic [127:0] ST4 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] EX4 = 128'h172b047eba77d626e169146355210c7d;
  localparam logic [127:0] ST5 = 128'h202122232425262728292a2b2c2d2e2f;
  localparam logic [127:0] EX5 = 128'h547b9432a6c2233dee4c950b42fac34e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Offers st, waits (bounded) for acceptance, then follows the transaction until
  // out_valid. Called at posedge+1; returns at the falling edge inside the DONE cycle.
  task automatic txn(input string tag, input logic [127:0] st, input logic [127:0] expv,
                     input int exp_acc, input int exp_lat);
    int           n;
    int           lat;
    int           nrd;
    logic [127:0] addrs;
    logic [127:0] got;
    logic         rdy_done;
    n        = 0;
    lat      = 0;
    nrd      = 0;
    addrs    = '0;
    got      = '0;
    rdy_done = 1'b1;
    in_state = st;
    in_valid = 1'b1;
    @(negedge clk);
    while (!m_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (m_rd_en) begin
        addrs = {addrs[119:0], m_rd_addr};
        nrd++;
      end
      if (m_out_valid) begin
        lat      = i;
        got      = m_out_state;
        rdy_done = m_in_ready;
      end
    end
    check({tag, " accept wait"}, 128'(n), 128'(exp_acc));
    check({tag, " out_valid latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " rd_en count"}, 128'(nrd), 128'd16);
    check({tag, " rd_addr sequence"}, addrs, st);
    check({tag, " out_state"}, got, expv);
    check({tag, " in_ready in done"}, 128'(rdy_done), 128'd0);
  endtask

  initial begin
    logic [127:0] inv_rows [16];
    int           bad;
    int           hold_bad;
    inv_rows = '{
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check("reset b1 ctrl", 128'({b1.in_ready, b1.rd_en, b1.rd_addr, b1.out_valid}), 128'd0);
    check("reset b1 out_state", b1.out_state, 128'd0);
    check("reset b2 ctrl", 128'({b2.in_ready, b2.rd_en, b2.rd_addr, b2.out_valid}), 128'd0);
    check("reset b2 out_state", b2.out_state, 128'd0);
    tick();
    reset = 1'b0;

    // Load the table while a state is already offered: nothing may be accepted.
    in_valid = 1'b1;
    in_state = ST2;
    bad      = 0;
    for (int a = 0; a < 256; a++) begin
      wr_en   = 1'b1;
      wr_addr = 8'(a);
      wr_data = inv_rows[a / 16][8 * (15 - (a % 16)) +: 8];
      @(negedge clk);
      if (b1.in_ready || b1.rd_en || b2.in_ready || b2.rd_en) bad++;
      tick();
    end
    wr_en = 1'b0;
    check("no accept while table not ready", 128'(bad), 128'd0);

    // ram_ready rises: one WAIT_TABLE cycle, then accepted.
    ram_ready = 1'b1;
    out_ready = 1'b1;
    txn("first after ready", ST1, EX1, 1, 18);
    tick();
    txn("basic", ST1, EX1, 0, 18);
    tick();
    txn("boundary bytes", ST2, EX2, 0, 18);
    tick();

    // Consumer stalls for 10 cycles in DONE.
    out_ready = 1'b0;
    txn("stall", ST3, EX3, 0, 18);
    tick();
    in_valid = 1'b1;
    in_state = ST4;
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!m_out_valid || m_out_state !== EX3 || m_in_ready || m_rd_en) hold_bad++;
      tick();
    end
    check("done held under stall", 128'(hold_bad), 128'd0);
    out_ready = 1'b1;
    txn("after stall", ST4, EX4, 1, 18);
    tick();

    // ram_ready drops in issue cycle 5.
    in_valid = 1'b1;
    in_state = ST3;
    @(negedge clk);
    check("abort txn accepted", 128'(m_in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    ram_ready = 1'b0;
    @(negedge clk);
    check("abort issue cycle 5", 128'({m_rd_en, m_rd_addr}), 128'h114);
    tick();
    @(negedge clk);
    check("abort next cycle", 128'({m_rd_en, m_in_ready, m_out_valid}), 128'd0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      @(negedge clk);
      if (m_out_valid || m_rd_en || m_in_ready) bad++;
    end
    check("quiet after abort", 128'(bad), 128'd0);
    tick();
    ram_ready = 1'b1;
    txn("after abort", ST5, EX5, 1, 18);
    tick();

    // Reset in READ cycle 8.
    in_valid = 1'b1;
    in_state = ST4;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    @(negedge clk);
    check("read cycle 8 strobe", 128'({m_rd_en, m_rd_addr}), 128'h1f7);
    tick();
    @(negedge clk);
    check("mid-read reset ctrl", 128'({b1.in_ready, b1.rd_en, b1.rd_addr, b1.out_valid}),
          128'd0);
    check("mid-read reset out_state", b1.out_state, 128'd0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Two-cycle RAM read latency.
    sel = 1'b1;
    txn("latency 2", ST1, EX1, 0, 19);
    tick();
    sel = 1'b0;
    txn("after reset", ST2, EX2, 0, 18);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inv_sbox_reader.md
Name: inv_sbox_reader

Overview:
Read-side client of the 256x8 inverse S-box RAM that the table loader fills. Once the table reports ram_ready, the block accepts one 128-bit AES state per transaction. It performs 16 sequential byte lookups through the RAM's single synchronous read port and returns the InvSubBytes result over a valid/ready output handshake. It sits between the decryption round datapath and the shared inverse S-box RAM.

Parameters:
NBYTES, 16, bytes per state and lookups per transaction.
RD_LATENCY, 1, cycles from rd_addr/rd_en to valid rd_data; legal values 1..2.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high reset.
ram_ready  in  1  table fully loaded; level signal from the loader.
in_valid  in  1  input state offered.
in_ready  out  1  block can accept a state.
in_state  in  [0:8*NBYTES-1]  input state; byte i = in_state[8i:8i+7], byte 0 is the MSB.
rd_en  out  1  RAM read strobe.
rd_addr  out  [0:7]  RAM read address.
rd_data  in  [0:7]  RAM read data, valid RD_LATENCY cycles after the strobe.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts the result.
out_state  out  [0:8*NBYTES-1]  substituted state, with the same byte order as in_state.

Behaviour:
- Reset: all outputs and registers go to 0, and the FSM goes to WAIT_TABLE. Reset overrides any in-flight transaction.
- FSM states:
  - WAIT_TABLE: in_ready=0. Moves to IDLE in the cycle after ram_ready is sampled 1.
  - IDLE: in_ready=1 combinationally, provided ram_ready=1. If in_valid&&in_ready at edge T0, in_state is latched, the issue and capture counters are cleared, and the FSM goes to READ. If ram_ready=0, the FSM goes to WAIT_TABLE.
  - READ: in_ready=0.
    - Issue: during cycles T0+1..T0+NBYTES, rd_en=1 and rd_addr=latched byte k, with k=0..NBYTES-1 in order.
    - Capture: rd_data for byte k is sampled at the end of cycle T0+1+k+RD_LATENCY into out_state byte k. Capture is tracked by a delayed-valid shift line of depth RD_LATENCY, not inferred from the issue counter.
    - After the last capture, the FSM goes to DONE.
    - rd_en=0 in any READ cycle after issue completes.
  - DONE: out_valid=1 and out_state is stable. When out_valid&&out_ready, out_valid drops next cycle and the FSM goes to IDLE. No back-to-back accept in the same cycle; in_ready=0 in DONE.
- Latency: out_valid first rises in cycle T0+1+NBYTES+RD_LATENCY, which is T0+18 at defaults. Throughput is one state per NBYTES+RD_LATENCY+2 cycles minimum.
- rd_en is 0 outside READ. rd_addr holds its last value when rd_en=0.
- out_state holds its value until the next capture begins. Bytes not yet captured are undefined to the consumer because out_valid=0.
- ram_ready falling during READ:
  - Abort: rd_en drops the next cycle and in-flight returns are discarded.
  - The FSM goes to WAIT_TABLE, and out_valid is never raised for that transaction.
- ram_ready falling during DONE: the result is still delivered. After the handshake, the FSM goes to WAIT_TABLE, not IDLE.
- out_ready held 1 continuously: DONE lasts exactly one cycle.
- Counters are 4 bits (clog2(NBYTES)) with no wrap. Issue stops at NBYTES-1; capture terminates on count == NBYTES-1 with the delayed-valid bit set.

Decomposition:
- Shared package aes_dec_pkg holds:
  - AES_NBYTES=16 and BYTE_W=8;
  - the reader FSM state encoding (WAIT_TABLE, IDLE, READ, DONE);
  - constant INV_SBOX_RD_LATENCY=1.
- One natural sub-module, inv_sbox_ram: the 256x8 RAM with one write port (loader side) and one synchronous read port with RD_LATENCY output registering. The bench instantiates it together with the existing loader to drive rd_data.

Test Plan:
- Load table, then in_state=000102030405060708090a0b0c0d0e0f -> out_state=52096ad53036a538bf40a39e81f3d7fb, out_valid at T0+18, rd_addr sequence 00..0f.
- Boundary bytes: in_state with byte0=63, byte1=ff, byte2=00, rest 01 -> out bytes 00, 7d, 52, then 09 x13.
- in_valid asserted while ram_ready=0 -> in_ready=0 and no rd_en. Raise ram_ready -> accepted one cycle later, with the correct result.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable, in_ready=0, no rd_en. Then out_ready=1 -> return to IDLE and accept the next state.
- Drop ram_ready at READ issue cycle 5 -> rd_en low next cycle, out_valid never rises, FSM in WAIT_TABLE. Reassert -> a fresh transaction completes correctly.
- Assert reset mid-READ (cycle 8) -> all outputs 0 next cycle. With RD_LATENCY=2, repeat test 1 -> out_valid at T0+19, same data.
